// File: rtl/mult_acc_pkg.sv
// Shared types and width derivation for the serial-multiplier MAC back end.
package mult_acc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Term counter width; at least one bit so N_TERMS = 1 still has a counter.
  function automatic int nb_cnt(input int n_terms);
    return (clog2(n_terms) < 1) ? 1 : clog2(n_terms);
  endfunction

  // Product width plus one growth bit per doubling of the term count.
  function automatic int nb_acc(input int nb_data, input int n_terms);
    return 2 * nb_data + nb_cnt(n_terms);
  endfunction

endpackage

// File: rtl/mult_accumulator_edge_detect_rise.sv
// Rising-edge detector: one pulse per low-to-high transition of i_sig.
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic sig_q;

  // History of the input, updated unconditionally every cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sig_q <= 1'b0;
    else        sig_q <= i_sig;
  end

  assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/mult_accumulator.sv
// Sums N_TERMS consecutive multiplier products and hands each frame sum
// downstream on a valid/ready port. The multiplier cannot be stalled, so
// products arriving while a sum is still pending are dropped and flagged.
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter  int NB_DATA = 4,
  parameter  int N_TERMS = 4,
  localparam int NB_CNT  = nb_cnt(N_TERMS),
  localparam int NB_ACC  = nb_acc(NB_DATA, N_TERMS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [2*NB_DATA-1:0] i_mult,
  input  logic                 i_mult_done,
  output logic [NB_ACC-1:0]    o_acc,
  output logic                 o_acc_valid,
  input  logic                 i_acc_ready,
  output logic [NB_CNT-1:0]    o_term_cnt,
  output logic                 o_overrun
);

  localparam logic [NB_CNT-1:0] LAST_TERM = NB_CNT'(N_TERMS - 1);

  state_e            state_q;
  logic [NB_ACC-1:0] acc_q;
  logic [NB_CNT-1:0] cnt_q;
  logic              valid_q;
  logic              ovr_q;

  logic              prod_evt;
  logic [NB_ACC-1:0] prod_ext;
  logic              hshake;

  // A done level held for many cycles must count as a single product.
  edge_detect_rise u_done_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sig   (i_mult_done),
    .o_pulse (prod_evt)
  );

  assign prod_ext = NB_ACC'(i_mult);
  assign hshake   = valid_q & i_acc_ready;

  // Frame FSM: accumulate in ACCUM, park the finished sum in HOLD.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (i_clear) begin
      // Abort wins over any product arriving this cycle; nothing is flagged.
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (prod_evt) begin
            acc_q <= acc_q + prod_ext;
            if (cnt_q == LAST_TERM) begin
              cnt_q   <= '0;
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q + NB_CNT'(1);
            end
          end
        end
        ST_HOLD: begin
          if (hshake) begin
            if (prod_evt) begin
              // The coinciding product opens the next frame rather than being lost.
              acc_q <= prod_ext;
              if (LAST_TERM == '0) begin
                cnt_q   <= '0;
                valid_q <= 1'b1;
                state_q <= ST_HOLD;
              end else begin
                cnt_q   <= NB_CNT'(1);
                valid_q <= 1'b0;
                state_q <= ST_ACCUM;
              end
            end else begin
              acc_q   <= '0;
              cnt_q   <= '0;
              valid_q <= 1'b0;
              state_q <= ST_ACCUM;
            end
          end else if (prod_evt) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign o_acc       = acc_q;
  assign o_acc_valid = valid_q;
  assign o_term_cnt  = cnt_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator with a frame-level reference model.
module tb_mult_accumulator;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_clear = 1'b0;
  logic [7:0] i_mult = '0;
  logic       i_mult_done = 1'b0;
  logic [9:0] o_acc;
  logic       o_acc_valid;
  logic       i_acc_ready = 1'b1;
  logic [1:0] o_term_cnt;
  logic       o_overrun;

  int checks = 0;
  int errors = 0;
  bit done_run = 1'b0;

  mult_accumulator #(.NB_DATA(4), .N_TERMS(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .i_mult      (i_mult),
    .i_mult_done (i_mult_done),
    .o_acc       (o_acc),
    .o_acc_valid (o_acc_valid),
    .i_acc_ready (i_acc_ready),
    .o_term_cnt  (o_term_cnt),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: products of the open frame in a queue, plus a pending sum.
  int  frame[$];
  bit  m_pend = 1'b0;
  int  m_pend_val = 0;
  bit  m_ovr = 1'b0;
  bit  m_prev = 1'b0;

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  function automatic int exp_acc();
    return m_pend ? m_pend_val : qsum(frame);
  endfunction

  initial begin
    forever begin
      @(posedge i_clk or negedge i_rst);
      if (!i_rst) begin
        frame.delete(); m_pend = 0; m_pend_val = 0; m_ovr = 0; m_prev = 0;
      end else begin
        bit evt;
        evt = i_mult_done && !m_prev;
        m_prev = i_mult_done;
        if (i_clear) begin
          frame.delete(); m_pend = 0; m_pend_val = 0; m_ovr = 0;
        end else if (m_pend && i_acc_ready) begin
          m_pend = 0;
          frame.delete();
          if (evt) frame.push_back(int'(i_mult));
        end else if (m_pend) begin
          if (evt) m_ovr = 1;
        end else if (evt) begin
          frame.push_back(int'(i_mult));
        end
        if (!m_pend && frame.size() == 4) begin
          m_pend = 1; m_pend_val = qsum(frame); frame.delete();
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (done_run) break;
      chk("model_acc",   int'(o_acc),       exp_acc());
      chk("model_valid", int'(o_acc_valid), int'(m_pend));
      chk("model_cnt",   int'(o_term_cnt),  frame.size());
      chk("model_ovr",   int'(o_overrun),   int'(m_ovr));
    end
  end

  // One-cycle done pulse carrying product v.
  task automatic pulse(input int v);
    @(negedge i_clk); i_mult_done = 1'b1; i_mult = 8'(v);
    @(negedge i_clk); i_mult_done = 1'b0;
  endtask

  int exp_cnt[4] = '{1, 2, 3, 0};
  int prods[4]   = '{3, 5, 7, 9};

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_acc", int'(o_acc), 0);
    chk("rst_valid", int'(o_acc_valid), 0);
    chk("rst_cnt", int'(o_term_cnt), 0);
    chk("rst_ovr", int'(o_overrun), 0);
    i_rst = 1'b1;

    // 3+5+7+9 with ready held high
    for (int k = 0; k < 4; k++) begin
      pulse(prods[k]);
      chk("seq_cnt", int'(o_term_cnt), exp_cnt[k]);
    end
    chk("sum24_acc", int'(o_acc), 24);
    chk("sum24_valid", int'(o_acc_valid), 1);
    @(negedge i_clk);
    chk("sum24_valid_drop", int'(o_acc_valid), 0);
    chk("sum24_acc_clr", int'(o_acc), 0);

    // Four maximal products: no wrap
    repeat (4) pulse(225);
    chk("max_acc", int'(o_acc), 900);
    chk("max_ovr", int'(o_overrun), 0);

    // Done held for six cycles counts once
    @(negedge i_clk); i_mult_done = 1'b1; i_mult = 8'd10;
    repeat (6) @(negedge i_clk);
    i_mult_done = 1'b0;
    chk("level_cnt", int'(o_term_cnt), 1);
    chk("level_acc", int'(o_acc), 10);
    pulse(6);
    chk("level2_cnt", int'(o_term_cnt), 2);
    chk("level2_acc", int'(o_acc), 16);
    pulse(1); pulse(2);
    chk("level_sum", int'(o_acc), 19);

    // Overrun while the consumer stalls
    @(negedge i_clk); i_acc_ready = 1'b0;
    pulse(1); pulse(2); pulse(3); pulse(4);
    repeat (2) @(negedge i_clk);
    pulse(50);
    chk("ovr_acc_held", int'(o_acc), 10);
    chk("ovr_valid_held", int'(o_acc_valid), 1);
    chk("ovr_flag", int'(o_overrun), 1);
    @(negedge i_clk); i_acc_ready = 1'b1;
    @(negedge i_clk);
    chk("ovr_after_valid", int'(o_acc_valid), 0);
    chk("ovr_after_acc", int'(o_acc), 0);
    chk("ovr_sticky", int'(o_overrun), 1);

    // Handshake coinciding with a product event
    i_acc_ready = 1'b0;
    repeat (4) pulse(1);
    chk("co_pre_acc", int'(o_acc), 4);
    @(negedge i_clk); i_acc_ready = 1'b1; i_mult_done = 1'b1; i_mult = 8'd12;
    @(negedge i_clk); i_mult_done = 1'b0;
    chk("co_valid", int'(o_acc_valid), 0);
    chk("co_acc", int'(o_acc), 12);
    chk("co_cnt", int'(o_term_cnt), 1);
    repeat (3) pulse(1);
    chk("co_sum", int'(o_acc), 15);

    // Asynchronous reset mid-frame
    pulse(2); pulse(3);
    chk("mid_cnt", int'(o_term_cnt), 2);
    chk("mid_acc", int'(o_acc), 5);
    #2 i_rst = 1'b0;
    #1;
    chk("arst_acc", int'(o_acc), 0);
    chk("arst_cnt", int'(o_term_cnt), 0);
    chk("arst_ovr", int'(o_overrun), 0);
    @(negedge i_clk); i_rst = 1'b1;

    // Clear while holding a sum, with a product in the same cycle
    i_acc_ready = 1'b0;
    pulse(1); pulse(2); pulse(3); pulse(4);
    pulse(50);
    chk("pre_clr_ovr", int'(o_overrun), 1);
    @(negedge i_clk); i_clear = 1'b1; i_mult_done = 1'b1; i_mult = 8'd7;
    @(negedge i_clk); i_clear = 1'b0; i_mult_done = 1'b0;
    chk("clr_acc", int'(o_acc), 0);
    chk("clr_valid", int'(o_acc_valid), 0);
    chk("clr_cnt", int'(o_term_cnt), 0);
    chk("clr_ovr", int'(o_overrun), 0);
    i_acc_ready = 1'b1;
    pulse(1); pulse(2); pulse(3); pulse(4);
    chk("post_clr_sum", int'(o_acc), 10);
    chk("post_clr_valid", int'(o_acc_valid), 1);

    repeat (3) @(negedge i_clk);
    done_run = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
